// File: rtl/pattern_stim_gen.sv
// Parametrised pattern generator for benches and board demos: up/down count,
// walking one or LFSR, advanced by a hold timer or a single-step request.
module pattern_stim_gen #(
  parameter int               WIDTH       = 6,
  parameter int               HOLD_CYCLES = 100,
  parameter logic [WIDTH-1:0] LFSR_TAPS   = WIDTH'(6'b110000)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_step,
  input  logic [1:0]       i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic [WIDTH-1:0] o_pattern,
  output logic             o_tick,
  output logic             o_wrap
);

  localparam int               CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]    TERM     = CW'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_pattern;
  logic             r_tick;
  logic             r_wrap;

  logic             w_term;
  logic             w_adv;
  logic             w_onehot;
  logic             w_fb;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap;

  assign w_term   = i_en && (r_cnt == TERM);
  assign w_adv    = w_term || (!i_en && i_step);
  assign w_onehot = (r_pattern != '0) && ((r_pattern & (r_pattern - ONE)) == '0);
  assign w_fb     = ^(r_pattern & LFSR_TAPS);

  always_comb begin
    w_next = r_pattern;
    w_wrap = 1'b0;
    case (i_mode)
      2'b00: begin
        w_next = r_pattern + ONE;
        w_wrap = &r_pattern;
      end
      2'b01: begin
        w_next = r_pattern - ONE;
        w_wrap = (r_pattern == '0);
      end
      2'b10: begin
        // Anything that is not a walkable one-hot restarts at bit 0.
        w_next = (w_onehot && (r_pattern != MSB_ONLY)) ? (r_pattern << 1) : ONE;
        w_wrap = (r_pattern == MSB_ONLY);
      end
      default: begin
        if (r_pattern == '0) begin
          w_next = ONE;
        end else begin
          w_next = {r_pattern[WIDTH-2:0], w_fb};
          w_wrap = (w_next == ONE);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_pattern <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (i_load) begin
      r_cnt     <= '0;
      r_pattern <= i_load_value;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_cnt     <= (!i_en || w_term) ? '0 : r_cnt + CW'(1);
      r_tick    <= w_adv;
      r_wrap    <= w_adv && w_wrap;
      if (w_adv) r_pattern <= w_next;
    end
  end

  assign o_pattern = r_pattern;
  assign o_tick    = r_tick;
  assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_pattern_stim_gen.sv
// Scoreboard bench for pattern_stim_gen (WIDTH=6, HOLD_CYCLES=4): stimulus queues
// each expected advance, a negedge monitor matches it against every tick.
module tb_pattern_stim_gen;

  logic       clk = 1'b0;
  logic       reset, en, step, load;
  logic [1:0] mode;
  logic [5:0] load_value;
  logic [5:0] pattern;
  logic       tick, wrap;

  pattern_stim_gen #(.WIDTH(6), .HOLD_CYCLES(4), .LFSR_TAPS(6'b110000)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_step(step), .i_mode(mode),
    .i_load(load), .i_load_value(load_value),
    .o_pattern(pattern), .o_tick(tick), .o_wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] pat;
    logic       wrp;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   fails  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every tick must match the oldest queued advance, at its cycle.
  always @(negedge clk) begin
    if (tick) begin
      if (sbq.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("adv_pattern", int'(pattern), int'(e.pat));
        chk("adv_wrap", int'(wrap), int'(e.wrp));
        chk("adv_cycle", cyc, e.cyc);
      end
    end else if (wrap) begin
      chk("wrap_without_tick", 1, 0);
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [5:0] p, input logic w, input int c);
    exp_t e;
    e.pat = p;
    e.wrp = w;
    e.cyc = c;
    sbq.push_back(e);
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < bound) begin
      tick_n(1);
      n++;
    end
    chk({name, "_drained"}, sbq.size(), 0);
    sbq.delete();
  endtask

  task automatic do_step(input logic [5:0] p, input logic w);
    step = 1'b1;
    push(p, w, cyc + 1);
    tick_n(1);
    step = 1'b0;
    tick_n(1);
  endtask

  initial begin
    int         base;
    logic [5:0] m;
    logic [5:0] lfsr_hand [6];

    reset = 1'b1; en = 1'b0; step = 1'b0; load = 1'b0;
    mode = 2'b00; load_value = '0;
    tick_n(2);
    chk("reset_pattern", int'(pattern), 0);
    chk("reset_tick", int'(tick), 0);
    chk("reset_wrap", int'(wrap), 0);

    // Up count: first advance 4 cycles after reset release, wrap on the 64th.
    reset = 1'b0; en = 1'b1; mode = 2'b00;
    base = cyc;
    for (int k = 1; k <= 64; k++) push(6'(k % 64), k == 64, base + 4 * k);
    tick_n(256);
    en = 1'b0;
    drain("up", 20);

    // Down count from reset: 0 -> 63 wraps, then 62.
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0; en = 1'b1; mode = 2'b01;
    base = cyc;
    push(6'd63, 1'b1, base + 4);
    push(6'd62, 1'b0, base + 8);
    tick_n(8);
    en = 1'b0;
    drain("down", 20);

    // Walking one after loading a non-one-hot value, stepped with en=0.
    mode = 2'b10; load = 1'b1; load_value = 6'b000101;
    tick_n(1);
    load = 1'b0;
    chk("walk_load_pattern", int'(pattern), 5);
    chk("walk_load_tick", int'(tick), 0);
    tick_n(3);
    do_step(6'd1, 1'b0);
    do_step(6'd2, 1'b0);
    do_step(6'd4, 1'b0);
    tick_n(3);
    do_step(6'd8, 1'b0);
    do_step(6'd16, 1'b0);
    do_step(6'd32, 1'b0);
    do_step(6'd1, 1'b1);
    drain("walk", 20);

    // LFSR from reset: escape to 1, then 63 advances back to 1 with wrap.
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0; mode = 2'b11;
    lfsr_hand[0] = 6'd1;  lfsr_hand[1] = 6'd2;  lfsr_hand[2] = 6'd4;
    lfsr_hand[3] = 6'd8;  lfsr_hand[4] = 6'd16; lfsr_hand[5] = 6'd33;
    for (int k = 1; k <= 6; k++) do_step(lfsr_hand[k-1], 1'b0);
    m = 6'd33;
    for (int k = 7; k <= 64; k++) begin
      m = {m[4:0], m[5] ^ m[4]};
      do_step(m, k == 64);
    end
    drain("lfsr", 20);

    // Load beats a coincident step; step is ignored while running.
    en = 1'b0; load = 1'b1; step = 1'b1; load_value = 6'd42;
    tick_n(1);
    load = 1'b0; step = 1'b0;
    chk("prio_load_pattern", int'(pattern), 42);
    chk("prio_load_tick", int'(tick), 0);
    mode = 2'b00; en = 1'b1;
    base = cyc;
    push(6'd43, 1'b0, base + 4);
    tick_n(1);
    step = 1'b1;
    tick_n(1);
    step = 1'b0;
    tick_n(2);
    en = 1'b0;
    tick_n(4);
    drain("prio", 20);

    // Reset mid-hold restarts the hold timer.
    load = 1'b1; load_value = 6'd9;
    tick_n(1);
    load = 1'b0;
    chk("midhold_load", int'(pattern), 9);
    en = 1'b1;
    tick_n(2);
    reset = 1'b1;
    tick_n(1);
    chk("midhold_reset_pattern", int'(pattern), 0);
    chk("midhold_reset_tick", int'(tick), 0);
    reset = 1'b0;
    base = cyc;
    push(6'd1, 1'b0, base + 4);
    tick_n(4);
    en = 1'b0;
    tick_n(4);
    drain("midhold", 20);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
